// File: rtl/input_router.sv
// Spike router: accumulates one source neuron's weight row into the excitatory or
// inhibitory dendritic sum RAM, and clears both dendritic RAMs on request.
module input_router #(
  parameter int NEURON_WIDTH = 11,
  parameter int DATA_WIDTH   = 44,
  parameter int ADDR_WIDTH   = 22
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    RouteEnable,
  input  logic                    Initialize,
  input  logic [NEURON_WIDTH-1:0] ExRangeLOWER,
  input  logic [NEURON_WIDTH-1:0] ExRangeUPPER,
  input  logic [NEURON_WIDTH-1:0] InRangeLOWER,
  input  logic [NEURON_WIDTH-1:0] InRangeUPPER,
  input  logic [NEURON_WIDTH-1:0] IPRangeLOWER,
  input  logic [NEURON_WIDTH-1:0] IPRangeUPPER,
  input  logic [NEURON_WIDTH-1:0] NeuStart,
  input  logic [NEURON_WIDTH-1:0] NeuEnd,
  input  logic [NEURON_WIDTH-1:0] NeuronID,
  input  logic [DATA_WIDTH-1:0]   WeightData,
  output logic                    WChipEnable,
  output logic                    WWriteEnable,
  output logic [ADDR_WIDTH-1:0]   WRAMAddress,
  input  logic [DATA_WIDTH-1:0]   ExWeightSum,
  input  logic [DATA_WIDTH-1:0]   InWeightSum,
  output logic                    EXChipEnable,
  output logic                    INChipEnable,
  output logic                    EXWriteEnable,
  output logic                    INWriteEnable,
  output logic [NEURON_WIDTH-1:0] EXAddress,
  output logic [NEURON_WIDTH-1:0] INAddress,
  output logic [DATA_WIDTH-1:0]   NewExWeightSum,
  output logic [DATA_WIDTH-1:0]   NewInWeightSum,
  output logic                    RoutingComplete
);

  typedef enum logic [2:0] {IDLE, INIT, RD, WR, DONE} stateT;

  stateT                   state, stateNext;
  logic [NEURON_WIDTH-1:0] i, iNext;
  logic [NEURON_WIDTH-1:0] lastIdx;
  logic [ADDR_WIDTH-1:0]   base;
  logic                    exPath, exPathNext;
  logic                    loadCfg;
  logic                    srcIsEx, srcIsIn;
  logic [NEURON_WIDTH:0]   nCount;
  logic signed [DATA_WIDTH-1:0] exSum, inSum, weight;

  function automatic logic inRange(input logic [NEURON_WIDTH-1:0] id,
                                   input logic [NEURON_WIDTH-1:0] lo,
                                   input logic [NEURON_WIDTH-1:0] hi);
    return (id >= lo) && (id <= hi);
  endfunction

  // Dendritic update wraps on overflow; no saturation is wanted here.
  function automatic logic signed [DATA_WIDTH-1:0] wrapAdd(input logic signed [DATA_WIDTH-1:0] a,
                                                           input logic signed [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign exSum   = ExWeightSum;
  assign inSum   = InWeightSum;
  assign weight  = WeightData;
  assign srcIsEx = inRange(NeuronID, IPRangeLOWER, IPRangeUPPER) ||
                   inRange(NeuronID, ExRangeLOWER, ExRangeUPPER);
  assign srcIsIn = inRange(NeuronID, InRangeLOWER, InRangeUPPER);
  assign nCount  = {1'b0, NeuEnd} - {1'b0, NeuStart} + (NEURON_WIDTH+1)'(1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      i     <= '0;
    end else begin
      state <= stateNext;
      i     <= iNext;
    end
  end

  // Route/clear parameters are frozen when leaving IDLE so input changes mid-run are ignored.
  always_ff @(posedge Clock) begin
    if (loadCfg) begin
      lastIdx <= NeuEnd - NeuStart;
      base    <= ADDR_WIDTH'(NeuronID) * ADDR_WIDTH'(nCount);
      exPath  <= exPathNext;
    end
  end

  always_comb begin
    stateNext       = state;
    iNext           = i;
    loadCfg         = 1'b0;
    exPathNext      = 1'b1;
    WChipEnable     = 1'b0;
    WWriteEnable    = 1'b0;
    WRAMAddress     = '0;
    EXChipEnable    = 1'b0;
    INChipEnable    = 1'b0;
    EXWriteEnable   = 1'b0;
    INWriteEnable   = 1'b0;
    EXAddress       = '0;
    INAddress       = '0;
    NewExWeightSum  = '0;
    NewInWeightSum  = '0;
    RoutingComplete = 1'b0;
    case (state)
      IDLE: begin
        iNext = '0;
        if (Initialize) begin
          stateNext = INIT;
          loadCfg   = 1'b1;
        end else if (RouteEnable) begin
          loadCfg = 1'b1;
          if (srcIsEx) begin
            stateNext  = RD;
            exPathNext = 1'b1;
          end else if (srcIsIn) begin
            stateNext  = RD;
            exPathNext = 1'b0;
          end else begin
            stateNext = DONE;
          end
        end
      end
      INIT: begin
        EXChipEnable  = 1'b1;
        INChipEnable  = 1'b1;
        EXWriteEnable = 1'b1;
        INWriteEnable = 1'b1;
        EXAddress     = i;
        INAddress     = i;
        if (i == lastIdx) begin
          stateNext = IDLE;
          iNext     = '0;
        end else begin
          iNext = i + NEURON_WIDTH'(1);
        end
      end
      RD: begin
        WChipEnable = 1'b1;
        WRAMAddress = base + ADDR_WIDTH'(i);
        if (exPath) begin
          EXChipEnable = 1'b1;
          EXAddress    = i;
        end else begin
          INChipEnable = 1'b1;
          INAddress    = i;
        end
        stateNext = WR;
      end
      WR: begin
        if (exPath) begin
          EXChipEnable   = 1'b1;
          EXWriteEnable  = 1'b1;
          EXAddress      = i;
          NewExWeightSum = wrapAdd(exSum, weight);
        end else begin
          INChipEnable   = 1'b1;
          INWriteEnable  = 1'b1;
          INAddress      = i;
          NewInWeightSum = wrapAdd(inSum, weight);
        end
        if (i == lastIdx) begin
          stateNext = DONE;
        end else begin
          iNext     = i + NEURON_WIDTH'(1);
          stateNext = RD;
        end
      end
      DONE: begin
        RoutingComplete = 1'b1;
        if (!RouteEnable) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_router.sv
// Bench for input_router: RAM models around the DUT, a table of route/clear
// operations, hand-written corner sequences and randomized routes vs. a reference model.
module tb_input_router;
  localparam int NW = 11;
  localparam int DW = 44;
  localparam int AW = 22;

  logic          Clock = 1'b0;
  logic          Reset, RouteEnable, Initialize;
  logic [NW-1:0] ExRangeLOWER, ExRangeUPPER, InRangeLOWER, InRangeUPPER;
  logic [NW-1:0] IPRangeLOWER, IPRangeUPPER, NeuStart, NeuEnd, NeuronID;
  logic [DW-1:0] WeightData, ExWeightSum, InWeightSum;
  logic          WChipEnable, WWriteEnable;
  logic [AW-1:0] WRAMAddress;
  logic          EXChipEnable, INChipEnable, EXWriteEnable, INWriteEnable;
  logic [NW-1:0] EXAddress, INAddress;
  logic [DW-1:0] NewExWeightSum, NewInWeightSum;
  logic          RoutingComplete;

  always #5 Clock = ~Clock;

  input_router #(.NEURON_WIDTH(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .RouteEnable(RouteEnable), .Initialize(Initialize),
    .ExRangeLOWER(ExRangeLOWER), .ExRangeUPPER(ExRangeUPPER),
    .InRangeLOWER(InRangeLOWER), .InRangeUPPER(InRangeUPPER),
    .IPRangeLOWER(IPRangeLOWER), .IPRangeUPPER(IPRangeUPPER),
    .NeuStart(NeuStart), .NeuEnd(NeuEnd), .NeuronID(NeuronID),
    .WeightData(WeightData), .WChipEnable(WChipEnable), .WWriteEnable(WWriteEnable),
    .WRAMAddress(WRAMAddress), .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
    .EXChipEnable(EXChipEnable), .INChipEnable(INChipEnable),
    .EXWriteEnable(EXWriteEnable), .INWriteEnable(INWriteEnable),
    .EXAddress(EXAddress), .INAddress(INAddress),
    .NewExWeightSum(NewExWeightSum), .NewInWeightSum(NewInWeightSum),
    .RoutingComplete(RoutingComplete)
  );

  logic anyOut;
  assign anyOut = |{WChipEnable, WWriteEnable, WRAMAddress, EXChipEnable, INChipEnable,
                    EXWriteEnable, INWriteEnable, EXAddress, INAddress,
                    NewExWeightSum, NewInWeightSum, RoutingComplete};

  // Weight RAM contents: a seeded hash of the address, with optional per-address overrides.
  int unsigned   wSeed;
  logic [DW-1:0] wOverride [int unsigned];

  function automatic logic [DW-1:0] wval(input int unsigned a);
    logic [63:0] h;
    if (wOverride.exists(a)) return wOverride[a];
    h = {a ^ wSeed, a * 32'h9E3779B1 + wSeed};
    return h[DW-1:0];
  endfunction

  logic [DW-1:0] exMem [0:2047];
  logic [DW-1:0] inMem [0:2047];
  logic          presetEn = 1'b0;
  logic [NW-1:0] presetAddr = '0;
  logic [DW-1:0] presetData = '0;

  always @(posedge Clock) begin
    if (WChipEnable && !WWriteEnable) WeightData <= wval(32'(WRAMAddress));
    if (presetEn) exMem[presetAddr] <= presetData;
    if (EXChipEnable) begin
      if (EXWriteEnable) exMem[EXAddress] <= NewExWeightSum;
      else ExWeightSum <= exMem[EXAddress];
    end
    if (INChipEnable) begin
      if (INWriteEnable) inMem[INAddress] <= NewInWeightSum;
      else InWeightSum <= inMem[INAddress];
    end
  end

  int wCeCnt = 0, exCeCnt = 0, inCeCnt = 0, wWeCnt = 0;
  always @(negedge Clock) begin
    if (WChipEnable)  wCeCnt  <= wCeCnt + 1;
    if (WWriteEnable) wWeCnt  <= wWeCnt + 1;
    if (EXChipEnable) exCeCnt <= exCeCnt + 1;
    if (INChipEnable) inCeCnt <= inCeCnt + 1;
  end

  // Reference model of the dendritic RAMs.
  logic [DW-1:0] refEx [0:2047];
  logic [DW-1:0] refIn [0:2047];
  int checks = 0, errors = 0;

  function automatic bit inRng(input int id, input int lo, input int hi);
    return id >= lo && id <= hi;
  endfunction

  function automatic bit isExSrc(input int id);
    return inRng(id, 0, 783) || inRng(id, 784, 1183);
  endfunction

  task automatic refInit(input int n);
    for (int k = 0; k < n; k++) begin
      refEx[k] = '0;
      refIn[k] = '0;
    end
  endtask

  task automatic refRoute(input int id, input int n);
    int unsigned base;
    base = (id * n) % (1 << 22);
    for (int k = 0; k < n; k++) begin
      if (isExSrc(id))              refEx[k] = refEx[k] + wval((base + k) % (1 << 22));
      else if (inRng(id, 1184, 1583)) refIn[k] = refIn[k] + wval((base + k) % (1 << 22));
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkMem(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int k = 0; k < 800; k++)
      if (exMem[k] !== refEx[k] || inMem[k] !== refIn[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d entries differ, first idx %0d ex got %h want %h, in got %h want %h",
               name, bad, first, exMem[first], refEx[first], inMem[first], refIn[first]);
    end
  endtask

  task automatic runInit(output int lat, output int fw);
    Initialize = 1'b1; lat = -1; fw = -1;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge Clock); #1;
      if (k == 3) Initialize = 1'b0;
      if (WChipEnable && fw < 0) fw = int'(WRAMAddress);
      if (!EXChipEnable) begin lat = k; break; end
    end
    Initialize = 1'b0;
  endtask

  task automatic runRoute(input int id, output int lat, output int fw);
    logic [NW-1:0] savedEnd;
    savedEnd = NeuEnd;
    NeuronID = NW'(id); RouteEnable = 1'b1; lat = -1; fw = -1;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge Clock); #1;
      if (k == 1) begin
        NeuronID = NW'($urandom_range(0, 2047));
        NeuEnd   = savedEnd ^ 11'h005;
      end
      if (WChipEnable && fw < 0) fw = int'(WRAMAddress);
      if (RoutingComplete) begin lat = k; break; end
    end
    NeuEnd = savedEnd;
    RouteEnable = 1'b0;
    @(posedge Clock); #1;
    check("idleAfterDrop", longint'(RoutingComplete), 0);
  endtask

  typedef struct {
    bit isInit; int id; int nStart; int nEnd;
    int expLat; int expFirstW; int expW; int expEx; int expIn;
  } vecT;

  vecT vecs [7];

  initial begin
    int lat, fw, w0, e0, i0, n, firstRd;
    logic [DW-1:0] twice;

    vecs[0] = '{1, 0,    784, 1583, 801,  -1,     0,   800,  800};
    vecs[1] = '{0, 400,  784, 1583, 1601, 320000, 800, 1600, 0};
    vecs[2] = '{0, 1200, 784, 1583, 1601, 960000, 800, 0,    1600};
    vecs[3] = '{1, 0,    784, 1583, 801,  -1,     0,   800,  800};
    vecs[4] = '{0, 800,  784, 1583, 1601, 640000, 800, 1600, 0};
    vecs[5] = '{0, 800,  784, 1583, 1601, 640000, 800, 1600, 0};
    vecs[6] = '{0, 2000, 784, 1583, 1,    -1,     0,   0,    0};

    wSeed = $urandom;
    Reset = 1'b1; RouteEnable = 1'b0; Initialize = 1'b0;
    IPRangeLOWER = 11'd0;    IPRangeUPPER = 11'd783;
    ExRangeLOWER = 11'd784;  ExRangeUPPER = 11'd1183;
    InRangeLOWER = 11'd1184; InRangeUPPER = 11'd1583;
    NeuStart = 11'd784; NeuEnd = 11'd1583; NeuronID = '0;
    for (int k = 0; k < 2048; k++) begin refEx[k] = '0; refIn[k] = '0; end

    #2 Reset = 1'b0;
    #1 check("resetOutputs", longint'(anyOut), 0);
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b1;
    w0 = wCeCnt; e0 = exCeCnt; i0 = inCeCnt;
    repeat (5) @(posedge Clock);
    #1;
    check("idleNoComplete", longint'(RoutingComplete), 0);
    check("idleNoCE", longint'(wCeCnt - w0 + exCeCnt - e0 + inCeCnt - i0), 0);

    for (int v = 0; v < 7; v++) begin
      NeuStart = NW'(vecs[v].nStart); NeuEnd = NW'(vecs[v].nEnd);
      n = vecs[v].nEnd - vecs[v].nStart + 1;
      w0 = wCeCnt; e0 = exCeCnt; i0 = inCeCnt;
      if (vecs[v].isInit) begin runInit(lat, fw); refInit(n); end
      else begin runRoute(vecs[v].id, lat, fw); refRoute(vecs[v].id, n); end
      check($sformatf("v%0d_latency", v), lat, vecs[v].expLat);
      check($sformatf("v%0d_firstWAddr", v), fw, vecs[v].expFirstW);
      check($sformatf("v%0d_wCE", v), wCeCnt - w0, vecs[v].expW);
      check($sformatf("v%0d_exCE", v), exCeCnt - e0, vecs[v].expEx);
      check($sformatf("v%0d_inCE", v), inCeCnt - i0, vecs[v].expIn);
      checkMem($sformatf("v%0d_mem", v));
    end
    twice = wval(640007) + wval(640007);
    check("doubleRoute", longint'(exMem[7]), longint'(twice));

    // Wrap-around: positive max plus one becomes most negative.
    NeuStart = 11'd0; NeuEnd = 11'd0;
    presetAddr = '0; presetData = 44'h7FF_FFFF_FFFF; presetEn = 1'b1;
    @(posedge Clock); #1 presetEn = 1'b0;
    refEx[0] = 44'h7FF_FFFF_FFFF;
    wOverride[800] = 44'd1;
    runRoute(800, lat, fw);
    refRoute(800, 1);
    check("wrapLatency", lat, 3);
    check("wrapValue", longint'(exMem[0]), longint'(44'h800_0000_0000));
    checkMem("wrapMem");

    // Route requested while INIT is still running.
    NeuStart = 11'd10; NeuEnd = 11'd14;
    Initialize = 1'b1; RouteEnable = 1'b1; NeuronID = 11'd100;
    firstRd = -1; fw = -1; lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge Clock); #1;
      if (k == 3) Initialize = 1'b0;
      if (WChipEnable && firstRd < 0) begin firstRd = k; fw = int'(WRAMAddress); end
      if (RoutingComplete) begin lat = k; break; end
    end
    Initialize = 1'b0; RouteEnable = 1'b0;
    @(posedge Clock); #1;
    refInit(5); refRoute(100, 5);
    check("queuedFirstRd", firstRd, 7);
    check("queuedFirstWAddr", fw, 500);
    check("queuedLatency", lat, 17);
    checkMem("queuedMem");

    // Asynchronous reset in the middle of a route.
    NeuStart = 11'd784; NeuEnd = 11'd1583; NeuronID = 11'd400; RouteEnable = 1'b1;
    repeat (10) @(posedge Clock);
    #1 Reset = 1'b0;
    #1 check("midRouteReset", longint'(anyOut), 0);
    RouteEnable = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    w0 = wCeCnt; e0 = exCeCnt; i0 = inCeCnt;
    repeat (3) @(posedge Clock);
    #1;
    check("postAbortIdle", longint'(wCeCnt - w0 + exCeCnt - e0 + inCeCnt - i0 + int'(RoutingComplete)), 0);
    runInit(lat, fw);
    refInit(800);
    check("reinitLatency", lat, 801);
    checkMem("reinitMem");

    // Randomized target ranges and sources.
    for (int r = 0; r < 6; r++) begin
      int st, id, expLat;
      st = $urandom_range(0, 1500);
      n  = $urandom_range(1, 24);
      NeuStart = NW'(st); NeuEnd = NW'(st + n - 1);
      runInit(lat, fw);
      refInit(n);
      check($sformatf("r%0d_initLatency", r), lat, n + 1);
      for (int q = 0; q < 3; q++) begin
        id = $urandom_range(0, 2047);
        expLat = (isExSrc(id) || inRng(id, 1184, 1583)) ? 2 * n + 1 : 1;
        runRoute(id, lat, fw);
        refRoute(id, n);
        check($sformatf("r%0d_%0d_latency_id%0d", r, q, id), lat, expLat);
      end
      checkMem($sformatf("r%0d_mem", r));
    end

    check("weightNeverWritten", wWeCnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
